// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered UART transmitter (start, 8 data LSB first, stop).
// Define UART_TX_PARITY_EN to add a parityOdd port and a parity bit before the stop bit.
module uart_tx #(
  parameter int CLOCK_SCALE_BITS = 16,
  parameter int FIFO_DEPTH_BITS = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CLOCK_SCALE_BITS-1:0] cyclesPerBit,
  input  logic [7:0]                  dataIn,
  input  logic                        dataWrite,
`ifdef UART_TX_PARITY_EN
  input  logic                        parityOdd,
`endif
  output logic                        tx,
  output logic                        fifoFull,
  output logic                        fifoEmpty,
  output logic                        busy
);
  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`ifdef UART_TX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t state;
  logic [7:0] mem [DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] rd_ptr, wr_ptr;
  logic [FIFO_DEPTH_BITS:0] count;
  logic [CLOCK_SCALE_BITS-1:0] div, period_m1;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic bit_end, pop, push, par_tx;
  assign fifoEmpty = count == '0;
  assign fifoFull = count == (FIFO_DEPTH_BITS+1)'(DEPTH);
  assign busy = state != IDLE;
  assign period_m1 = cyclesPerBit == '0 ? '0 : cyclesPerBit - CLOCK_SCALE_BITS'(1);
  assign bit_end = div == '0;
  // Full is judged before any same-cycle pop, so a write while full is always dropped.
  assign push = dataWrite && !fifoFull;
  assign pop = !fifoEmpty && (state == IDLE || (state == STOP && bit_end));
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= dataIn;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_DEPTH_BITS'(1);
      if (pop) rd_ptr <= rd_ptr + FIFO_DEPTH_BITS'(1);
      count <= count + (FIFO_DEPTH_BITS+1)'(push) - (FIFO_DEPTH_BITS+1)'(pop);
    end
`ifdef UART_TX_PARITY_EN
  logic par_bit;
  always_ff @(posedge clk or negedge rst)
    if (!rst) par_bit <= 1'b0;
    else if (pop) par_bit <= ^mem[rd_ptr] ^ parityOdd;
  assign par_tx = par_bit;
`else
  assign par_tx = 1'b1;
`endif
  // tx is a register fed from the current state, so the line lags the state by one cycle.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      div <= '0;
      bit_cnt <= '0;
      shift <= '0;
      tx <= 1'b1;
    end else begin
      tx <= state == START ? 1'b0 : state == DATA ? shift[0] : state == PARITY ? par_tx : 1'b1;
      if (pop) begin
        state <= START;
        div <= period_m1;
        shift <= mem[rd_ptr];
      end else if (state != IDLE) begin
        if (!bit_end) div <= div - CLOCK_SCALE_BITS'(1);
        else if (state == STOP) state <= IDLE;
        else begin
          div <= period_m1;
          if (state == START) begin
            state <= DATA;
            bit_cnt <= '0;
          end else if (state == DATA) begin
            shift <= shift >> 1;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= AFTER_DATA;
          end else state <= STOP;
        end
      end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized bench for uart_tx checked every cycle against a
// frame-level model (byte queue plus a queue of pending line bits).
module tb_uart_tx;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int A5_BUSY = 44;
  localparam logic [15:0] EXP81 = 16'h0205;
  localparam int FRAME = 11;
  logic parity_odd = 1'b0;
`else
  localparam int A5_BUSY = 40;
  localparam logic [15:0] EXP81 = 16'h0103;
  localparam int FRAME = 10;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [15:0] cpb = 16'd4;
  logic [7:0] data_in = 8'h00;
  logic data_write = 1'b0;
  logic tx, fifo_full, fifo_empty, busy;
  int n_tests = 0;
  int n_fail = 0;
  byte unsigned m_q[$];
  bit m_bits[$];
  bit m_active = 1'b0;
  bit m_cur = 1'b1;
  bit m_tx = 1'b1;
  int m_rem = 0;

  uart_tx dut (
    .clk(clk), .rst(rst), .cyclesPerBit(cpb), .dataIn(data_in), .dataWrite(data_write),
`ifdef UART_TX_PARITY_EN
    .parityOdd(parity_odd),
`endif
    .tx(tx), .fifoFull(fifo_full), .fifoEmpty(fifo_empty), .busy(busy));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge of the reference: the line shows the bit chosen before the edge.
  task automatic model_edge();
    int per = cpb == 16'd0 ? 1 : int'(cpb);
    bit nxt_tx = m_active ? m_cur : 1'b1;
    bit can_pop = m_q.size() != 0;
    bit can_wr = m_q.size() < DEPTH;
    if (m_active) begin
      if (m_rem > 1) m_rem--;
      else if (m_bits.size() != 0) begin
        m_cur = m_bits.pop_front();
        m_rem = per;
      end else m_active = 1'b0;
    end
    if (!m_active && can_pop) begin
      byte unsigned b = m_q.pop_front();
      m_bits.delete();
      for (int i = 0; i < 8; i++) m_bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
      m_bits.push_back(^b ^ parity_odd);
`endif
      m_bits.push_back(1'b1);
      m_cur = 1'b0;
      m_rem = per;
      m_active = 1'b1;
    end
    if (data_write && can_wr) m_q.push_back(data_in);
    m_tx = nxt_tx;
  endtask

  task automatic step(input bit w, input logic [7:0] d);
    data_write = w;
    data_in = d;
    @(posedge clk);
    model_edge();
    #1;
    check("tx", tx, m_tx);
    check("busy", busy, m_active);
    check("fifoEmpty", fifo_empty, m_q.size() == 0);
    check("fifoFull", fifo_full, m_q.size() == DEPTH);
    data_write = 1'b0;
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_empty", fifo_empty, 1);
    check("rst_full", fifo_full, 0);
    m_q.delete();
    m_bits.delete();
    m_active = 1'b0;
    m_tx = 1'b1;
    m_rem = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    int busy_cycles;
    logic [15:0] seq;
    repeat (2) @(posedge clk);
    #1;
    check("init_tx", tx, 1);
    check("init_busy", busy, 0);
    check("init_empty", fifo_empty, 1);
    check("init_full", fifo_full, 0);
    rst = 1'b1;
    cpb = 16'd4;
    step(1'b1, 8'hA5);
    busy_cycles = 0;
    repeat (50) begin
      step(1'b0, 8'h00);
      busy_cycles += int'(busy);
    end
    check("a5_busy_cycles", busy_cycles, A5_BUSY);
    cpb = 16'd0;
    step(1'b1, 8'h81);
    seq = '0;
    for (int i = 1; i <= 12; i++) begin
      step(1'b0, 8'h00);
      if (i >= 2 && i <= FRAME + 1) seq = {seq[14:0], tx};
    end
    check("frame_81", seq, EXP81);
    cpb = 16'd3;
    step(1'b1, 8'h00);
    step(1'b1, 8'hFF);
    step(1'b1, 8'h55);
    step(1'b1, 8'h0F);
    step(1'b1, 8'h33);
    check("full_after_burst", fifo_full, 1);
    repeat (200) step(1'b0, 8'h00);
    cpb = 16'd8;
    step(1'b1, 8'h3C);
    step(1'b1, 8'h11);
    step(1'b1, 8'h22);
    repeat (33) step(1'b0, 8'h00);
    do_reset();
    repeat (60) step(1'b0, 8'h00);
`ifdef UART_TX_PARITY_EN
    cpb = 16'd2;
    parity_odd = 1'b0;
    step(1'b1, 8'h07);
    repeat (30) step(1'b0, 8'h00);
    parity_odd = 1'b1;
    step(1'b1, 8'h07);
    repeat (30) step(1'b0, 8'h00);
`endif
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 149) == 0) cpb = 16'($urandom_range(0, 5));
`ifdef UART_TX_PARITY_EN
      parity_odd = 1'($urandom_range(0, 1));
`endif
      if ($urandom_range(0, 999) == 0) do_reset();
      step($urandom_range(0, 2) == 0, 8'($urandom));
    end
    cpb = 16'd1;
    repeat (100) step(1'b0, 8'h00);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
